paddle_sequencer: RTL
=====================

# paddle_sequencer

Converts the per-player paddle sources into the pad-timing pulse that the Breakout core measures. Digital inputs are integrated into per-player positions once per frame. The active player's target is latched at frame start. Scan lines are then counted while the core enables the pad measurement. The block sits between hps_io/keyboard decode and breakout_top (`PAD_OUT`, `PAD_EN_N`), replacing ad-hoc glue in emu.

## Interface
Parameters:
- `POS_INIT`, 114: reset and mode-7 position.
- `DELTA_SLOW`, 4: digital step per frame when `speed`=0.
- `DELTA_FAST`, 8: digital step per frame when `speed`=1.

Ports:
- `clk_sys` in 1: single clock (57.272 MHz).
- `reset` in 1: synchronous, active-high.
- `hsync`, `vsync` in 1: core sync outputs, active-high, clk_sys domain.
- `pad_en_n` in 1: core measurement enable; low = hold/clear.
- `player2` in 1: core active-player flag.
- `p1_mode`, `p2_mode` in 3: source select. 0 digital, 1 ~X, 2 X, 3 ~Y, 4 Y, 5 ~paddle, 6 paddle, 7 `POS_INIT`.
- `speed` in 1: selects `DELTA_FAST`.
- `p1_left`, `p1_right`, `p2_left`, `p2_right` in 1: digital controls, level.
- `p1_ax`, `p1_ay`, `p2_ax`, `p2_ay` in 8: signed analog stick axes.
- `paddle_0`, `paddle_1` in 8: unsigned paddle values.
- `pad_out` out 1: pad comparator pulse to core.
- `pos_out` out 8: currently latched frame target (debug/OSD).

## Operation
- Edge detect:
  - `hs_edge` = `hsync` & ~`hsync_q`; `vs_edge` likewise.
  - `*_q` registers reset to 1, so a level that is high at reset release produces no edge.
- Digital accumulators: `acc1` and `acc2`, 9-bit, reset to `POS_INIT`. On `vs_edge`, each player updates independently:
  - right only: acc = (acc < delta) ? 0 : acc − delta.
  - left only: acc = min(acc + delta, 255).
  - both or neither: unchanged.
- Analog conversion: offset = {~ax[7], ax[6:0]}. The same conversion applies to Y.
- Source mux: per the mode encoding above. Mode 0 uses `acc[7:0]`. The mux uses the player's own stick and paddle (`paddle_0` for P1, `paddle_1` for P2).
- Frame latch: on `vs_edge`, `frame_tgt` is set to the mux output of `player2 ? P2 : P1`.
  - `player2` and the modes are sampled only here.
  - The mux sees the pre-update accumulator value; the step applies from the next frame.
  - `pos_out` = `frame_tgt`.
- Measurement FSM:
  - IDLE: `cnt`=0. When `pad_en_n`=1, set `meas_tgt` ← `frame_tgt` and go to COUNT.
  - COUNT: `cnt` += 1 on each `hs_edge`. When the incremented `cnt` equals `meas_tgt`, go to DONE. If `meas_tgt`=0, go to DONE on entry without counting.
  - DONE: `cnt` holds, with no wrap and no further increment.
  - `pad_en_n`=0 in any state sends the FSM to IDLE with `cnt`=0 on the next clock. This has priority over an `hs_edge` in the same cycle.
- `pad_out`: registered, = (state≠DONE) & (`meas_tgt`≠0 | state=IDLE) & (`cnt` < `meas_tgt`). In IDLE the comparison uses `frame_tgt`.
- Simultaneous `vs_edge` and `hs_edge`: both are processed in the same cycle. `frame_tgt` changes do not affect a COUNT in progress.

## Timing
- Reset values:
  - state IDLE, `cnt`=0.
  - `acc1` = `acc2` = `frame_tgt` = `meas_tgt` = `POS_INIT`.
  - `pad_out`=0, `pos_out`=`POS_INIT`.
- An edge is seen in the cycle the raw input is first high. Registered state is updated on that clock and visible one cycle later.
- `pad_out` lags the `cnt`/state update by 1 clk. It falls 1 clk after the `hs_edge` that brings `cnt` to `meas_tgt`.
- Throughput: one increment per `hs_edge`. Consecutive edges are at least 2 clk apart by construction.
- Reset asserted mid-COUNT: all state returns to reset values on the next clock. No partial pulse is emitted afterwards.

## Test plan
- Reset: assert `reset` 2 clk with `hsync`/`vsync` high, then release. Required: `pad_out`=0, `pos_out`=114, and no edge is detected.
- Right clamp: mode 0, `acc1`=2, `speed`=0, `p1_right` held, 1 `vsync`. Required: `acc1`=0. Next frame: `pos_out`=0, and `pad_out` stays 0 through COUNT.
- Left saturate: `acc1`=250, `speed`=1, `p1_left` held, 2 vsyncs. Required: `acc1`=255. Left and right both held for 3 vsyncs leaves `acc1` unchanged.
- Count: `frame_tgt`=3, raise `pad_en_n`, apply 8 hsync pulses. Required: `pad_out` is 1 until 1 clk after the 3rd `hs_edge`, then 0 through the remaining 5.
- Abort: `pad_en_n` falls after 2 of 5 edges, then rises again. Required: IDLE with `cnt`=0, and a fresh 5-edge count is produced.
- Mode and player: `p2_mode`=1, `p2_ax`=0x80, `player2` toggles 0→1 mid-frame. Required: `pos_out` is unchanged until the next `vsync`, then becomes 0xFF.

Source files
------------

// File: rtl/paddle_sequencer.sv
// paddle_sequencer: integrates paddle sources per frame and emits the pad-timing pulse.
module paddle_sequencer #(
    parameter logic [7:0] POS_INIT   = 8'd114,
    parameter logic [7:0] DELTA_SLOW = 8'd4,
    parameter logic [7:0] DELTA_FAST = 8'd8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       pad_en_n,
    input  logic       player2,
    input  logic [2:0] p1_mode,
    input  logic [2:0] p2_mode,
    input  logic       speed,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p2_left,
    input  logic       p2_right,
    input  logic [7:0] p1_ax,
    input  logic [7:0] p1_ay,
    input  logic [7:0] p2_ax,
    input  logic [7:0] p2_ay,
    input  logic [7:0] paddle_0,
    input  logic [7:0] paddle_1,
    output logic       pad_out,
    output logic [7:0] pos_out
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t     state;
    logic       hsync_q, vsync_q, hs_edge, vs_edge;
    logic [8:0] acc1, acc2, delta;
    logic [7:0] frame_tgt, meas_tgt, cnt;

    assign hs_edge = hsync & ~hsync_q;
    assign vs_edge = vsync & ~vsync_q;
    assign delta   = {1'b0, speed ? DELTA_FAST : DELTA_SLOW};
    assign pos_out = frame_tgt;

    function automatic logic [8:0] step(input logic [8:0] acc, input logic l, input logic r, input logic [8:0] d);
        return (r & ~l) ? ((acc < d) ? 9'd0 : acc - d) :
               (l & ~r) ? ((acc + d > 9'd255) ? 9'd255 : acc + d) : acc;
    endfunction

    // Signed stick axes become unsigned positions by flipping the sign bit.
    function automatic logic [7:0] src(input logic [2:0] mode, input logic [7:0] acc,
                                       input logic [7:0] ax, input logic [7:0] ay, input logic [7:0] pad);
        logic [7:0] x, y;
        x = {~ax[7], ax[6:0]};
        y = {~ay[7], ay[6:0]};
        case (mode)
            3'd0:    return acc;
            3'd1:    return ~x;
            3'd2:    return x;
            3'd3:    return ~y;
            3'd4:    return y;
            3'd5:    return ~pad;
            3'd6:    return pad;
            default: return POS_INIT;
        endcase
    endfunction

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            acc1      <= {1'b0, POS_INIT};
            acc2      <= {1'b0, POS_INIT};
            frame_tgt <= POS_INIT;
            meas_tgt  <= POS_INIT;
            cnt       <= 8'd0;
            state     <= IDLE;
            pad_out   <= 1'b0;
        end else begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            if (vs_edge) begin
                acc1      <= step(acc1, p1_left, p1_right, delta);
                acc2      <= step(acc2, p2_left, p2_right, delta);
                frame_tgt <= player2 ? src(p2_mode, acc2[7:0], p2_ax, p2_ay, paddle_1)
                                     : src(p1_mode, acc1[7:0], p1_ax, p1_ay, paddle_0);
            end
            pad_out <= (state != DONE) && (meas_tgt != 8'd0 || state == IDLE) &&
                       (cnt < ((state == IDLE) ? frame_tgt : meas_tgt));
            if (!pad_en_n) begin
                state <= IDLE;
                cnt   <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        meas_tgt <= frame_tgt;
                        state    <= (frame_tgt == 8'd0) ? DONE : COUNT;
                    end
                    COUNT: if (hs_edge) begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == meas_tgt) state <= DONE;
                    end
                    DONE:    state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
